// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD issue arbiter: state and owner encodings,
// bus widths and the two-way round-robin pick.
package sd_cmd_pkg;

   localparam int CMD_IDX_W = 6;
   localparam int CMD_ARG_W = 32;
   localparam int TIMEOUT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_FINISH = 3'd3,
      ST_GAP    = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_SW   = 1'b0,
      OWN_AUTO = 1'b1
   } owner_t;

   // With both requesters pending the one that did not finish last wins.
   function automatic owner_t rr_pick(input logic sw_req, input logic auto_req,
                                      input owner_t last_owner);
      owner_t w;
      w = OWN_SW;
      if (sw_req && auto_req) begin
         if (last_owner == OWN_SW) w = OWN_AUTO;
         else                      w = OWN_SW;
      end else if (auto_req) begin
         w = OWN_AUTO;
      end
      return w;
   endfunction

endpackage

// File: rtl/cmd_issue_arbiter_if.sv
// Requester and CMD-layer signals of the issue arbiter. The master modport is
// the arbiter's view; the slave modport is the requesters / CMD layer view.
interface cmd_issue_arbiter_if;
   import sd_cmd_pkg::*;

   logic                 sw_req;
   logic [CMD_IDX_W-1:0] sw_cmd_index;
   logic [CMD_ARG_W-1:0] sw_cmd_arg;
   logic [TIMEOUT_W-1:0] sw_timeout;
   logic                 sw_grant;
   logic                 sw_done;
   logic                 sw_error;
   logic                 auto_req;
   logic [CMD_IDX_W-1:0] auto_cmd_index;
   logic [CMD_ARG_W-1:0] auto_cmd_arg;
   logic                 auto_grant;
   logic                 auto_done;
   logic                 auto_error;
   logic [CMD_ARG_W-1:0] resp_arg;
   logic [CMD_IDX_W-1:0] resp_index;
   logic                 arb_busy;
   logic                 new_cmd;
   logic [CMD_ARG_W-1:0] cmd_arg;
   logic [CMD_IDX_W-1:0] cmd_index;
   logic [TIMEOUT_W-1:0] timeout_value;
   logic                 cmd_busy;
   logic                 cmd_complete;
   logic                 timeout_error;
   logic [CMD_ARG_W-1:0] response_arg;
   logic [CMD_IDX_W-1:0] response_index;

   modport master (
      input  sw_req, sw_cmd_index, sw_cmd_arg, sw_timeout,
      input  auto_req, auto_cmd_index, auto_cmd_arg,
      input  cmd_busy, cmd_complete, timeout_error, response_arg, response_index,
      output sw_grant, sw_done, sw_error, auto_grant, auto_done, auto_error,
      output resp_arg, resp_index, arb_busy, new_cmd, cmd_arg, cmd_index, timeout_value
   );

   modport slave (
      output sw_req, sw_cmd_index, sw_cmd_arg, sw_timeout,
      output auto_req, auto_cmd_index, auto_cmd_arg,
      output cmd_busy, cmd_complete, timeout_error, response_arg, response_index,
      input  sw_grant, sw_done, sw_error, auto_grant, auto_done, auto_error,
      input  resp_arg, resp_index, arb_busy, new_cmd, cmd_arg, cmd_index, timeout_value
   );

endinterface

// File: rtl/cmd_req_rr_sel.sv
// Two-input round-robin selector. Holds the owner of the last finished
// transaction and names the winner among the currently pending requests.
module cmd_req_rr_sel
   import sd_cmd_pkg::*;
(
   input  logic   CLK_host,
   input  logic   reset,
   input  logic   sw_req,
   input  logic   auto_req,
   input  logic   update,
   input  owner_t owner,
   output logic   req_valid,
   output owner_t winner
);

   owner_t last_owner_q;
   owner_t last_owner_d;

   // Take the finishing owner as the new last owner.
   always_comb begin
      last_owner_d = last_owner_q;
      if (update) last_owner_d = owner;
   end

   // Last owner register; after reset software wins the first contention.
   always_ff @(posedge CLK_host or posedge reset) begin
      if (reset) last_owner_q <= OWN_AUTO;
      else       last_owner_q <= last_owner_d;
   end

   // Winner of the current request levels.
   always_comb begin
      req_valid = sw_req | auto_req;
      winner    = rr_pick(sw_req, auto_req, last_owner_q);
   end

endmodule

// File: rtl/cmd_issue_arbiter.sv
// Shares the SD CMD transaction layer between the software register path and
// the DAT-block auto-command path: grant, issue, wait, retry on timeout,
// report, then hold an idle gap before the next command.
module cmd_issue_arbiter
   import sd_cmd_pkg::*;
#(
   parameter int                   RETRY_MAX    = 2,
   parameter int                   GAP_CYCLES   = 8,
   parameter logic [TIMEOUT_W-1:0] AUTO_TIMEOUT = 16'd200
) (
   input logic                 CLK_host,
   input logic                 reset,
   cmd_issue_arbiter_if.master bus
);

   localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
   localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   arb_state_t           state_q, state_d;
   owner_t               owner_q, owner_d;
   logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 retry_flag_q, retry_flag_d;
   logic [CMD_ARG_W-1:0] cmd_arg_q, cmd_arg_d;
   logic [CMD_IDX_W-1:0] cmd_index_q, cmd_index_d;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
   logic [CMD_ARG_W-1:0] resp_arg_q, resp_arg_d;
   logic [CMD_IDX_W-1:0] resp_index_q, resp_index_d;
   logic                 sw_grant_q, sw_grant_d, auto_grant_q, auto_grant_d;
   logic                 sw_done_q, sw_done_d, auto_done_q, auto_done_d;
   logic                 sw_error_q, sw_error_d, auto_error_q, auto_error_d;
   logic                 new_cmd_q, new_cmd_d;
   logic                 finish_now, finish_err;
   logic                 sel_valid;
   owner_t               sel_winner;

   cmd_req_rr_sel u_rr_sel (
      .CLK_host  (CLK_host),
      .reset     (reset),
      .sw_req    (bus.sw_req),
      .auto_req  (bus.auto_req),
      .update    (state_q == ST_FINISH),
      .owner     (owner_q),
      .req_valid (sel_valid),
      .winner    (sel_winner)
   );

   // Next-state, latch and pulse logic of the issue sequencer.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      retry_cnt_d  = retry_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      retry_flag_d = retry_flag_q;
      cmd_arg_d    = cmd_arg_q;
      cmd_index_d  = cmd_index_q;
      timeout_d    = timeout_q;
      resp_arg_d   = resp_arg_q;
      resp_index_d = resp_index_q;
      sw_grant_d   = 1'b0;
      auto_grant_d = 1'b0;
      sw_done_d    = 1'b0;
      auto_done_d  = 1'b0;
      sw_error_d   = 1'b0;
      auto_error_d = 1'b0;
      new_cmd_d    = 1'b0;
      finish_now   = 1'b0;
      finish_err   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.cmd_busy && sel_valid) begin
               owner_d      = sel_winner;
               retry_cnt_d  = '0;
               retry_flag_d = 1'b0;
               state_d      = ST_ISSUE;
               if (sel_winner == OWN_SW) begin
                  cmd_index_d = bus.sw_cmd_index;
                  cmd_arg_d   = bus.sw_cmd_arg;
                  timeout_d   = bus.sw_timeout;
                  sw_grant_d  = 1'b1;
               end else begin
                  cmd_index_d  = bus.auto_cmd_index;
                  cmd_arg_d    = bus.auto_cmd_arg;
                  timeout_d    = AUTO_TIMEOUT;
                  auto_grant_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            new_cmd_d = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion takes priority over a simultaneous timeout.
            if (bus.cmd_complete) begin
               resp_arg_d   = bus.response_arg;
               resp_index_d = bus.response_index;
               finish_now   = 1'b1;
               state_d      = ST_FINISH;
            end else if (bus.timeout_error) begin
               if (retry_cnt_q < RETRY_LIM) begin
                  retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
                  retry_flag_d = 1'b1;
                  gap_cnt_d    = '0;
                  state_d      = ST_GAP;
               end else begin
                  finish_now = 1'b1;
                  finish_err = 1'b1;
                  state_d    = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            retry_flag_d = 1'b0;
            gap_cnt_d    = '0;
            state_d      = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_q >= GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = retry_flag_q ? ST_ISSUE : ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Done/error land in the FINISH cycle, steered to the owner.
      if (finish_now) begin
         sw_done_d    = (owner_q == OWN_SW);
         auto_done_d  = (owner_q == OWN_AUTO);
         sw_error_d   = (owner_q == OWN_SW) && finish_err;
         auto_error_d = (owner_q == OWN_AUTO) && finish_err;
      end
   end

   // State, latches, counters and registered outputs.
   always_ff @(posedge CLK_host or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_SW;
         retry_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         retry_flag_q <= 1'b0;
         cmd_arg_q    <= '0;
         cmd_index_q  <= '0;
         timeout_q    <= '0;
         resp_arg_q   <= '0;
         resp_index_q <= '0;
         sw_grant_q   <= 1'b0;
         auto_grant_q <= 1'b0;
         sw_done_q    <= 1'b0;
         auto_done_q  <= 1'b0;
         sw_error_q   <= 1'b0;
         auto_error_q <= 1'b0;
         new_cmd_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         retry_cnt_q  <= retry_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         retry_flag_q <= retry_flag_d;
         cmd_arg_q    <= cmd_arg_d;
         cmd_index_q  <= cmd_index_d;
         timeout_q    <= timeout_d;
         resp_arg_q   <= resp_arg_d;
         resp_index_q <= resp_index_d;
         sw_grant_q   <= sw_grant_d;
         auto_grant_q <= auto_grant_d;
         sw_done_q    <= sw_done_d;
         auto_done_q  <= auto_done_d;
         sw_error_q   <= sw_error_d;
         auto_error_q <= auto_error_d;
         new_cmd_q    <= new_cmd_d;
      end
   end

   assign bus.sw_grant      = sw_grant_q;
   assign bus.auto_grant    = auto_grant_q;
   assign bus.sw_done       = sw_done_q;
   assign bus.auto_done     = auto_done_q;
   assign bus.sw_error      = sw_error_q;
   assign bus.auto_error    = auto_error_q;
   assign bus.resp_arg      = resp_arg_q;
   assign bus.resp_index    = resp_index_q;
   assign bus.arb_busy      = (state_q != ST_IDLE);
   assign bus.new_cmd       = new_cmd_q;
   assign bus.cmd_arg       = cmd_arg_q;
   assign bus.cmd_index     = cmd_index_q;
   assign bus.timeout_value = timeout_q;

endmodule

// File: tb/tb_cmd_issue_arbiter.sv
// Scoreboard bench for cmd_issue_arbiter: expected grants, issued commands and
// done reports are queued when stimulus is driven and checked as they appear.
module tb_cmd_issue_arbiter;
   import sd_cmd_pkg::*;

   localparam int          RETRY_MAX  = 2;
   localparam int          GAP_CYCLES = 8;
   localparam logic [15:0] AUTO_TMO   = 16'd200;

   typedef struct { logic [5:0] idx; logic [31:0] arg; logic [15:0] tmo; } exp_cmd_t;
   typedef struct { bit is_auto; bit err; logic [31:0] rarg; logic [5:0] ridx; } exp_done_t;
   typedef struct { int dly; bit cpl; bit tmo; logic [31:0] rarg; logic [5:0] ridx; } rsp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_end = 0;
   bit   have_end = 1'b0;
   logic [31:0] m_resp_arg;
   logic [5:0]  m_resp_idx;
   bit          m_last_auto;

   exp_cmd_t  exp_cmd_q[$];
   exp_done_t exp_done_q[$];
   bit        exp_grant_q[$];
   rsp_t      rsp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_issue_arbiter_if bus ();

   cmd_issue_arbiter #(
      .RETRY_MAX    (RETRY_MAX),
      .GAP_CYCLES   (GAP_CYCLES),
      .AUTO_TIMEOUT (AUTO_TMO)
   ) dut (
      .CLK_host (clk),
      .reset    (rst),
      .bus      (bus)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.sw_done || bus.auto_done) seen = 1'b1;
      end
      check_val("done_seen", seen, 1);
   endtask

   // One requester alone: n_tmo leading timeouts, then success unless retries run out.
   task automatic do_txn(input bit is_auto, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [15:0] tmo, input int dly, input int n_tmo, input bit both,
                         input logic [31:0] rarg, input logic [5:0] ridx);
      exp_cmd_t  c;
      exp_done_t d;
      rsp_t      r;
      int        n_att;
      c.idx = idx;
      c.arg = arg;
      c.tmo = is_auto ? AUTO_TMO : tmo;
      exp_grant_q.push_back(is_auto);
      n_att = (n_tmo > RETRY_MAX) ? RETRY_MAX + 1 : n_tmo + 1;
      for (int a = 0; a < n_att; a++) begin
         exp_cmd_q.push_back(c);
         r.dly = dly;
         if (a < n_tmo) begin
            r.cpl = 1'b0; r.tmo = 1'b1; r.rarg = 32'hDEAD_0000 | a; r.ridx = 6'h3F;
         end else begin
            r.cpl = 1'b1; r.tmo = both; r.rarg = rarg; r.ridx = ridx;
         end
         rsp_q.push_back(r);
      end
      d.is_auto = is_auto;
      d.err     = (n_tmo > RETRY_MAX);
      if (!d.err) begin
         m_resp_arg = rarg;
         m_resp_idx = ridx;
      end
      d.rarg = m_resp_arg;
      d.ridx = m_resp_idx;
      exp_done_q.push_back(d);
      m_last_auto = is_auto;

      if (is_auto) begin
         bus.auto_req = 1'b1; bus.auto_cmd_index = idx; bus.auto_cmd_arg = arg;
      end else begin
         bus.sw_req = 1'b1; bus.sw_cmd_index = idx; bus.sw_cmd_arg = arg; bus.sw_timeout = tmo;
      end
      @(negedge clk);
      check_val("lat_grant", is_auto ? bus.auto_grant : bus.sw_grant, 1);
      // Drop the request and scramble the data: the latched copy must be used.
      bus.sw_req = 1'b0; bus.auto_req = 1'b0;
      bus.sw_cmd_index = ~idx; bus.sw_cmd_arg = ~arg; bus.sw_timeout = ~tmo;
      bus.auto_cmd_index = ~idx; bus.auto_cmd_arg = ~arg;
      @(negedge clk);
      check_val("lat_new_cmd", bus.new_cmd, 1);
      wait_done(2000);
      repeat (GAP_CYCLES) @(negedge clk);
      check_val("gap_busy", bus.arb_busy, 1);
      @(negedge clk);
      check_val("back_idle", bus.arb_busy, 0);
   endtask

   // Scoreboard monitor: pops expectations as grants, commands and dones appear.
   initial begin : mon
      exp_cmd_t  c;
      exp_done_t d;
      bit        g;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.sw_grant || bus.auto_grant) begin
               if (exp_grant_q.size() == 0) check_val("unexp_grant", 1, 0);
               else begin
                  g = exp_grant_q.pop_front();
                  check_val("grant_sw", bus.sw_grant, !g);
                  check_val("grant_auto", bus.auto_grant, g);
               end
            end
            if (bus.new_cmd) begin
               if (exp_cmd_q.size() == 0) check_val("unexp_cmd", 1, 0);
               else begin
                  c = exp_cmd_q.pop_front();
                  check_val("cmd_index", bus.cmd_index, c.idx);
                  check_val("cmd_arg", bus.cmd_arg, c.arg);
                  check_val("timeout_value", bus.timeout_value, c.tmo);
                  if (have_end) check_val("cmd_gap", (cyc - last_end) >= GAP_CYCLES + 2, 1);
               end
            end
            if (bus.sw_done || bus.auto_done) begin
               if (exp_done_q.size() == 0) check_val("unexp_done", 1, 0);
               else begin
                  d = exp_done_q.pop_front();
                  check_val("done_auto", bus.auto_done, d.is_auto);
                  check_val("done_sw", bus.sw_done, !d.is_auto);
                  check_val("done_err", d.is_auto ? bus.auto_error : bus.sw_error, d.err);
                  check_val("resp_arg", bus.resp_arg, d.rarg);
                  check_val("resp_index", bus.resp_index, d.ridx);
               end
               last_end = cyc;
               have_end = 1'b1;
            end
         end
      end
   end

   // CMD layer model: answers each new_cmd after the planned delay.
   initial begin : rsp
      rsp_t cur;
      int   cnt;
      cnt = 0;
      bus.cmd_complete = 1'b0; bus.timeout_error = 1'b0;
      bus.response_arg = '0;   bus.response_index = '0;
      forever begin
         @(negedge clk);
         bus.cmd_complete  = 1'b0;
         bus.timeout_error = 1'b0;
         if (rst) cnt = 0;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.cmd_complete   = cur.cpl;
               bus.timeout_error  = cur.tmo;
               bus.response_arg   = cur.rarg;
               bus.response_index = cur.ridx;
               if (cur.tmo && !cur.cpl) begin
                  last_end = cyc;
                  have_end = 1'b1;
               end
            end
         end else if (bus.new_cmd && rsp_q.size() > 0) begin
            cur = rsp_q.pop_front();
            cnt = cur.dly;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      exp_cmd_t  c;
      exp_done_t d;
      rsp_t      r;
      bit        w;
      bit        seen;
      int        g;
      rst = 1'b1;
      bus.sw_req = 1'b0; bus.sw_cmd_index = '0; bus.sw_cmd_arg = '0; bus.sw_timeout = '0;
      bus.auto_req = 1'b0; bus.auto_cmd_index = '0; bus.auto_cmd_arg = '0;
      bus.cmd_busy = 1'b0;
      m_resp_arg = '0; m_resp_idx = '0; m_last_auto = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_busy", bus.arb_busy, 0);
      check_val("rst_cmd_arg", bus.cmd_arg, 0);
      check_val("rst_timeout", bus.timeout_value, 0);
      check_val("rst_pulses", {bus.new_cmd, bus.sw_grant, bus.auto_grant, bus.sw_done, bus.auto_done}, 0);
      rst = 1'b0;

      // Plain software command.
      do_txn(1'b0, 6'd17, 32'h0000_0200, 16'd200, 40, 0, 1'b0, 32'h900, 6'd17);

      // Both requesters held: winners alternate starting from the non-last owner.
      for (int k = 0; k < 3; k++) begin
         w = !m_last_auto;
         exp_grant_q.push_back(w);
         c.idx = w ? 6'd12 : 6'd17;
         c.arg = w ? 32'h0000_0000 : 32'h0000_0300;
         c.tmo = w ? AUTO_TMO : 16'd77;
         exp_cmd_q.push_back(c);
         r.dly = 12; r.cpl = 1'b1; r.tmo = 1'b0; r.rarg = 32'h5000 + k; r.ridx = 6'd20 + 6'(k);
         rsp_q.push_back(r);
         m_resp_arg = r.rarg; m_resp_idx = r.ridx;
         d.is_auto = w; d.err = 1'b0; d.rarg = r.rarg; d.ridx = r.ridx;
         exp_done_q.push_back(d);
         m_last_auto = w;
      end
      bus.sw_req = 1'b1;   bus.sw_cmd_index = 6'd17;  bus.sw_cmd_arg = 32'h300; bus.sw_timeout = 16'd77;
      bus.auto_req = 1'b1; bus.auto_cmd_index = 6'd12; bus.auto_cmd_arg = 32'h0;
      g = 0;
      for (int i = 0; i < 2000 && g < 3; i++) begin
         @(negedge clk);
         if (bus.sw_grant || bus.auto_grant) g++;
      end
      bus.sw_req = 1'b0; bus.auto_req = 1'b0;
      check_val("contend_grants", g, 3);
      for (int i = 0; i < 2000 && (bus.arb_busy || exp_done_q.size() != 0); i++) @(negedge clk);
      check_val("contend_idle", bus.arb_busy, 0);

      // Every attempt times out: three issues, one error report, resp_* unchanged.
      do_txn(1'b0, 6'd8, 32'h1234_5678, 16'd50, 20, 3, 1'b0, 32'h0, 6'd0);
      // Auto path: timeout then success.
      do_txn(1'b1, 6'd13, 32'hA5A5_0001, 16'd0, 15, 1, 1'b0, 32'h0000_0B00, 6'd13);
      // Complete and timeout together count as success.
      do_txn(1'b0, 6'd55, 32'hFFFF_FFFF, 16'hFFFF, 5, 0, 1'b1, 32'h1357_9BDF, 6'd55);

      // Requests are not taken while the CMD layer is busy.
      bus.cmd_busy = 1'b1;
      bus.sw_req = 1'b1; bus.sw_cmd_index = 6'd3; bus.sw_cmd_arg = 32'h33; bus.sw_timeout = 16'd9;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.sw_grant || bus.arb_busy) seen = 1'b1;
      end
      bus.sw_req = 1'b0; bus.cmd_busy = 1'b0;
      @(negedge clk);
      if (bus.sw_grant || bus.arb_busy) seen = 1'b1;
      check_val("busy_block", seen, 0);

      // Reset while waiting for the response: abort with no done.
      exp_grant_q.push_back(1'b0);
      c.idx = 6'd2; c.arg = 32'h0000_CAFE; c.tmo = 16'd99;
      exp_cmd_q.push_back(c);
      r.dly = 30; r.cpl = 1'b1; r.tmo = 1'b0; r.rarg = 32'h1; r.ridx = 6'd1;
      rsp_q.push_back(r);
      bus.sw_req = 1'b1; bus.sw_cmd_index = 6'd2; bus.sw_cmd_arg = 32'h0000_CAFE; bus.sw_timeout = 16'd99;
      @(negedge clk);
      bus.sw_req = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_busy", bus.arb_busy, 0);
      check_val("arst_cmd_arg", bus.cmd_arg, 0);
      check_val("arst_cmd_index", bus.cmd_index, 0);
      check_val("arst_timeout", bus.timeout_value, 0);
      check_val("arst_resp_arg", bus.resp_arg, 0);
      check_val("arst_resp_index", bus.resp_index, 0);
      check_val("arst_done", {bus.sw_done, bus.sw_error, bus.new_cmd}, 0);
      rsp_q.delete();
      m_resp_arg = '0; m_resp_idx = '0; m_last_auto = 1'b1;
      have_end = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // Fresh request after the aborted one.
      do_txn(1'b0, 6'd7, 32'h0000_0077, 16'd300, 10, 0, 1'b0, 32'h0000_4242, 6'd7);

      check_val("sb_drain", exp_cmd_q.size() + exp_done_q.size() + exp_grant_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
